// File: rtl/dsptest_pkg.sv
// rtl/dsptest_pkg.sv - shared states, LFSR taps and step/fold helpers for the DSP test sequencer
package dsptest_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        STROBE,
        POST,
        CAPTURE,
        DONE
    } state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    // Widest response the fold helper accepts; narrower responses are zero-padded up to it.
    localparam int FOLD_MAX = 256;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? LFSR_TAPS : 32'h0);
    endfunction

    function automatic logic [31:0] fold32(input logic [FOLD_MAX-1:0] r);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < FOLD_MAX / 32; i++) begin
            acc = acc ^ r[i*32 +: 32];
        end
        return acc;
    endfunction

endpackage

// File: rtl/dsptest_lfsr32.sv
// rtl/dsptest_lfsr32.sv - 32-bit Galois LFSR with load and XOR inject, used as stimulus source and MISR
module dsptest_lfsr32
    import dsptest_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'h1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        en,
    input  logic [31:0] inject,
    output logic [31:0] lfsr_q
);

    logic [31:0] r_lfsr;
    logic [31:0] w_lfsr_d;

    always_comb begin
        w_lfsr_d = r_lfsr;
        if (load) begin
            w_lfsr_d = seed;
        end else if (en) begin
            w_lfsr_d = lfsr_step(r_lfsr) ^ inject;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lfsr <= RESET_VAL;
        end else begin
            r_lfsr <= w_lfsr_d;
        end
    end

    assign lfsr_q = r_lfsr;

endmodule

// File: rtl/dsptest_vector_seq.sv
// rtl/dsptest_vector_seq.sv - DSP test vector sequencer: stim/strobe/capture loop with MISR signature
// Optional response log outputs are enabled by `DSPTEST_RESP_LOG_EN.
module dsptest_vector_seq
    import dsptest_pkg::*;
#(
    parameter int          STIM_WIDTH  = 32,
    parameter int          RESP_WIDTH  = 32,
    parameter int          N_WARMUP    = 10,
    parameter int          N_VECTORS   = 1000,
    parameter int          PRE_CYCLES  = 5,
    parameter int          POST_CYCLES = 5,
    parameter logic [31:0] LFSR_SEED   = 32'h1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    output logic [STIM_WIDTH-1:0] stim,
    output logic                  strobe,
    input  logic [RESP_WIDTH-1:0] resp,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           vec_count,
    output logic [31:0]           signature
`ifdef DSPTEST_RESP_LOG_EN
    ,
    output logic                  resp_log_valid,
    output logic [RESP_WIDTH-1:0] resp_log_data
`endif
);

    localparam int              PH_MAX    = (PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES;
    localparam int              PH_W      = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] PRE_LAST  = PH_W'(PRE_CYCLES - 1);
    localparam logic [PH_W-1:0] POST_LAST = PH_W'(POST_CYCLES - 1);
    localparam logic [31:0]     WARM32    = 32'(N_WARMUP);
    localparam logic [31:0]     TOTAL32   = 32'(N_WARMUP + N_VECTORS);
    localparam logic [31:0]     SEED_EFF  = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

    state_e                r_state;
    state_e                w_next_state;
    logic [PH_W-1:0]       r_phase;
    logic [31:0]           r_vec_count;
    logic [STIM_WIDTH-1:0] r_stim;
    logic [STIM_WIDTH-1:0] w_stim_rand;
    logic [31:0]           w_lfsr_q;
    logic [31:0]           w_lfsr_next;
    logic [31:0]           w_misr_q;
    logic [31:0]           w_next_idx;
    logic [FOLD_MAX-1:0]   w_resp_pad;
    logic                  w_start_run;
    logic                  w_capture;
    logic                  w_advance;
    logic                  w_last;
    logic                  w_next_warm;

    assign w_start_run = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_capture   = (r_state == CAPTURE);
    assign w_advance   = w_capture && (r_vec_count >= WARM32);
    assign w_last      = (r_vec_count + 32'd1) == TOTAL32;
    assign w_resp_pad  = FOLD_MAX'(resp);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next_state = PRE;
            PRE:        if (r_phase == PRE_LAST) w_next_state = STROBE;
            STROBE:     w_next_state = POST;
            POST:       if (r_phase == POST_LAST) w_next_state = CAPTURE;
            CAPTURE:    w_next_state = w_last ? DONE : PRE;
            default:    w_next_state = IDLE;
        endcase
    end

    // Stim for the vector about to start is derived from the LFSR value it will hold after this edge.
    always_comb begin
        w_next_idx  = w_start_run ? 32'd0 : (r_vec_count + 32'd1);
        w_next_warm = w_next_idx < WARM32;
        if (w_start_run) begin
            w_lfsr_next = SEED_EFF;
        end else if (w_advance) begin
            w_lfsr_next = lfsr_step(w_lfsr_q);
        end else begin
            w_lfsr_next = w_lfsr_q;
        end
        w_stim_rand = '0;
        for (int i = 0; i < STIM_WIDTH; i++) begin
            w_stim_rand[i] = w_lfsr_next[i % 32];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_phase     <= '0;
            r_vec_count <= '0;
            r_stim      <= '1;
        end else begin
            r_state <= w_next_state;
            if (r_state != w_next_state) begin
                r_phase <= '0;
            end else if ((r_state == PRE) || (r_state == POST)) begin
                r_phase <= r_phase + PH_W'(1);
            end
            if (w_start_run) begin
                r_vec_count <= '0;
                r_stim      <= w_next_warm ? '1 : w_stim_rand;
            end else if (w_capture) begin
                r_vec_count <= r_vec_count + 32'd1;
                if (!w_last) begin
                    r_stim <= w_next_warm ? '1 : w_stim_rand;
                end
            end
        end
    end

    dsptest_lfsr32 #(.RESET_VAL(SEED_EFF)) u_stim_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .load   (w_start_run),
        .seed   (SEED_EFF),
        .en     (w_advance),
        .inject (32'h0),
        .lfsr_q (w_lfsr_q)
    );

    dsptest_lfsr32 #(.RESET_VAL(32'h0)) u_misr (
        .clk    (clk),
        .resetn (resetn),
        .load   (w_start_run),
        .seed   (32'h0),
        .en     (w_advance),
        .inject (fold32(w_resp_pad)),
        .lfsr_q (w_misr_q)
    );

`ifdef DSPTEST_RESP_LOG_EN
    logic                  r_log_valid;
    logic [RESP_WIDTH-1:0] r_log_data;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_log_valid <= 1'b0;
            r_log_data  <= '0;
        end else begin
            r_log_valid <= w_capture;
            if (w_capture) begin
                r_log_data <= resp;
            end
        end
    end

    assign resp_log_valid = r_log_valid;
    assign resp_log_data  = r_log_data;
`endif

    assign stim      = r_stim;
    assign strobe    = (r_state == STROBE);
    assign busy      = (r_state != IDLE) && (r_state != DONE);
    assign done      = (r_state == DONE);
    assign vec_count = r_vec_count;
    assign signature = w_misr_q;

endmodule

// File: tb/tb_dsptest_vector_seq.sv
// tb/tb_dsptest_vector_seq.sv - scoreboard bench for dsptest_vector_seq (honours `DSPTEST_RESP_LOG_EN)
module tb_dsptest_vector_seq;

    localparam int          STIM_W = 72;
    localparam int          RESP_W = 48;
    localparam int          NW     = 2;
    localparam int          NV     = 3;
    localparam int          PRE_C  = 5;
    localparam int          POST_C = 5;
    localparam logic [31:0] SEED   = 32'h1234ABCD;
    localparam int          TOT    = NW + NV;
    localparam int          PERIOD = PRE_C + POST_C + 2;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic [STIM_W-1:0] stim;
    logic              strobe;
    logic [RESP_W-1:0] resp = '0;
    logic              busy;
    logic              done;
    logic [31:0]       vec_count;
    logic [31:0]       signature;
`ifdef DSPTEST_RESP_LOG_EN
    logic              resp_log_valid;
    logic [RESP_W-1:0] resp_log_data;
`endif

    dsptest_vector_seq #(
        .STIM_WIDTH(STIM_W), .RESP_WIDTH(RESP_W), .N_WARMUP(NW), .N_VECTORS(NV),
        .PRE_CYCLES(PRE_C), .POST_CYCLES(POST_C), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .stim(stim), .strobe(strobe),
        .resp(resp), .busy(busy), .done(done), .vec_count(vec_count), .signature(signature)
`ifdef DSPTEST_RESP_LOG_EN
        , .resp_log_valid(resp_log_valid), .resp_log_data(resp_log_data)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [STIM_W-1:0] stim; int off; } strobe_exp_t;
    typedef struct { int off; logic [31:0] vc; logic [31:0] sig; } done_exp_t;

    strobe_exp_t       exp_q[$];
    done_exp_t         done_q[$];
    logic [RESP_W-1:0] resp_q[$];
    logic [RESP_W-1:0] resp_arr[TOT];
    int                t0 = 0;
    int                n_pass = 0;
    int                n_total = 0;
    int                log_cnt = 0;
    logic              prev_done = 1'b0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] m_step(input logic [31:0] x);
        logic [31:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 32'h80200003;
        return y;
    endfunction

    function automatic logic [31:0] m_fold(input logic [RESP_W-1:0] r);
        logic [31:0] acc;
        acc = '0;
        for (int b = 0; b < RESP_W; b++) acc[b % 32] ^= r[b];
        return acc;
    endfunction

    function automatic logic [STIM_W-1:0] m_stim(input int k);
        logic [31:0]       w;
        logic [STIM_W-1:0] s;
        if (k < NW) return {STIM_W{1'b1}};
        w = SEED;
        repeat (k - NW) w = m_step(w);
        for (int i = 0; i < STIM_W; i++) s[i] = w[i % 32];
        return s;
    endfunction

    // DUT-side model: presents the next queued response as soon as a strobe is seen.
    always @(negedge clk) begin
        if (resetn && strobe && resp_q.size() > 0) resp = resp_q.pop_front();
    end

    always @(negedge clk) begin
        strobe_exp_t e;
        done_exp_t   d;
        if (resetn && strobe) begin
            if (exp_q.size() == 0) chk("strobe_unexpected", 96'd1, 96'd0);
            else begin
                e = exp_q.pop_front();
                chk("stim", 96'(stim), 96'(e.stim));
                chk("strobe_time", 96'(cyc - t0), 96'(e.off));
            end
        end
        if (resetn && done && !prev_done) begin
            if (done_q.size() == 0) chk("done_unexpected", 96'd1, 96'd0);
            else begin
                d = done_q.pop_front();
                chk("done_time", 96'(cyc - t0), 96'(d.off));
                chk("vec_count", 96'(vec_count), 96'(d.vc));
                chk("signature", 96'(signature), 96'(d.sig));
                chk("busy_at_done", 96'(busy), 96'd0);
            end
        end
        prev_done = done;
`ifdef DSPTEST_RESP_LOG_EN
        if (resp_log_valid) log_cnt++;
`endif
    end

    // mode 0 random, 1 all-zero, 2 random warmup + DEADBEEF, 3 replay previous responses
    task automatic start_run(input int mode);
        strobe_exp_t e;
        done_exp_t   d;
        logic [31:0] sig;
        logic [63:0] rr;
        exp_q.delete(); done_q.delete(); resp_q.delete();
        log_cnt = 0;
        sig = '0;
        for (int k = 0; k < TOT; k++) begin
            rr = {$urandom(), $urandom()};
            if (mode == 0) resp_arr[k] = rr[RESP_W-1:0];
            else if (mode == 1) resp_arr[k] = '0;
            else if (mode == 2) resp_arr[k] = (k < NW) ? rr[RESP_W-1:0] : 48'h0000DEADBEEF;
            e.stim = m_stim(k);
            e.off  = k * PERIOD + PRE_C;
            exp_q.push_back(e);
            resp_q.push_back(resp_arr[k]);
            if (k >= NW) sig = m_step(sig) ^ m_fold(resp_arr[k]);
        end
        d.off = TOT * PERIOD;
        d.vc  = 32'(TOT);
        d.sig = sig;
        done_q.push_back(d);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        t0 = cyc;
        chk("busy_after_start", 96'(busy), 96'd1);
        chk("done_after_start", 96'(done), 96'd0);
        chk("vec_count_cleared", 96'(vec_count), 96'd0);
        chk("signature_cleared", 96'(signature), 96'd0);
    endtask

    task automatic finish_run(input bit extra_start);
        int i;
        i = 0;
        while (!done && i < 2000) begin
            @(negedge clk);
            start = extra_start && (cyc == t0 + 20);
            i++;
        end
        start = 1'b0;
        chk("done_reached", 96'(done), 96'd1);
        repeat (3) @(negedge clk);
        chk("done_held", 96'(done), 96'd1);
        chk("vec_count_held", 96'(vec_count), 96'(TOT));
        chk("all_strobes_seen", 96'(exp_q.size()), 96'd0);
`ifdef DSPTEST_RESP_LOG_EN
        chk("log_pulses", 96'(log_cnt), 96'(TOT));
`endif
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stim"}, 96'(stim), 96'({STIM_W{1'b1}}));
        chk({tag, "_strobe"}, 96'(strobe), 96'd0);
        chk({tag, "_busy"}, 96'(busy), 96'd0);
        chk({tag, "_done"}, 96'(done), 96'd0);
        chk({tag, "_vec_count"}, 96'(vec_count), 96'd0);
        chk({tag, "_signature"}, 96'(signature), 96'd0);
`ifdef DSPTEST_RESP_LOG_EN
        chk({tag, "_log_valid"}, 96'(resp_log_valid), 96'd0);
        chk({tag, "_log_data"}, 96'(resp_log_data), 96'd0);
`endif
    endtask

    initial begin
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_reset_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 96'(busy), 96'd0);

        start_run(0); finish_run(1'b0);
        start_run(1); finish_run(1'b0);
        start_run(2); finish_run(1'b0);
        start_run(0); finish_run(1'b1);
        start_run(3); finish_run(1'b0);

        start_run(0);
        while (cyc < t0 + PERIOD + PRE_C + 3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk_reset_outputs("abort");
        @(negedge clk);
        start_run(3); finish_run(1'b0);

        for (int r = 0; r < 3; r++) begin
            start_run(0); finish_run(1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
